// File: rtl/multicycle_cpu_core.sv
// Multi-cycle processor core: FETCH/DECODE/EXEC/MEM sequencing over a
// single-port request/acknowledge memory bus, parametrised datapath width,
// register count and address width.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_RST    | held in reset; bus idle
// S_FETCH  | read instruction at pc; latch it on ack
// S_DECODE | one idle cycle between fetch and execute
// S_EXEC   | ALU ops retire; LOAD/STORE move to MEM; BRANCH/HALT resolve
// S_MEM    | data access held until ack; LOAD writes back on completion
// S_HALTED | stopped by HALT until the next reset
module multicycle_cpu_core #(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 16,
  parameter int ADDR_W   = 12,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [4:0]        psr
);

  localparam int RIW = $clog2(NREGS);
  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

  localparam logic [3:0] OP_LOAD  = 4'b0001;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_BR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_ADD   = 4'b0101;
  localparam logic [3:0] OP_ROT   = 4'b0110;
  localparam logic [3:0] OP_SHIFT = 4'b0111;
  localparam logic [3:0] OP_HALT  = 4'b1000;
  localparam logic [3:0] OP_COMP  = 4'b1001;

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALTED
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [4:0]        psr_q, psr_d;
  logic [DATA_W-1:0] regs_q [NREGS];

  logic              reg_we;
  logic [DATA_W-1:0] reg_wd;

  logic [3:0]        op, cc;
  logic              src_type;
  logic [11:0]       src, dest;
  logic [DATA_W-1:0] opnd_s, rd_val;
  logic [10:0]       amt, rot_amt;
  logic              amt_in_range;
  logic              take;

  logic [DATA_W-1:0]        alu_y;
  logic                     alu_c;
  logic [DATA_W:0]          add_x, shl_x;
  logic signed [DATA_W:0]   shr_x;
  logic [2*DATA_W-1:0]      rot_l, rot_r;

  assign op       = ir_q[31:28];
  assign cc       = ir_q[27:24];
  assign src_type = ir_q[27];
  assign src      = ir_q[23:12];
  assign dest     = ir_q[11:0];

  assign opnd_s = src_type ? DATA_W'(src) : regs_q[src[RIW-1:0]];
  assign rd_val = regs_q[dest[RIW-1:0]];

  // Shift amount is taken raw; rotate amount folds modulo the word width.
  assign amt          = src[10:0];
  assign rot_amt      = 11'(32'(amt) % 32'(DATA_W));
  assign amt_in_range = 32'(amt) < 32'(DATA_W);

  // PSR packing {zero, negative, even, parity, carry}.
  function automatic logic [4:0] flags(input logic [DATA_W-1:0] y, input logic c);
    return {(y == '0), y[DATA_W-1], ~y[0], ^y, c};
  endfunction

  // ALU result and carry for the register-writing opcodes.
  always_comb begin
    alu_y = rd_val;
    alu_c = 1'b0;
    add_x = {1'b0, rd_val} + {1'b0, opnd_s};
    rot_l = {rd_val, rd_val} << rot_amt;
    rot_r = {rd_val, rd_val} >> rot_amt;
    shl_x = {1'b0, rd_val} << amt;
    shr_x = $signed({rd_val, 1'b0}) >>> amt;
    case (op)
      OP_XOR: alu_y = rd_val ^ opnd_s;
      OP_ADD: {alu_c, alu_y} = add_x;
      OP_ROT: begin
        if (src[11]) begin
          alu_y = rot_l[2*DATA_W-1:DATA_W];
          alu_c = (rot_amt != '0) && alu_y[0];
        end else begin
          alu_y = rot_r[DATA_W-1:0];
          alu_c = (rot_amt != '0) && alu_y[DATA_W-1];
        end
      end
      OP_SHIFT: begin
        // The guard bit appended below/above the word catches the last bit out.
        if (src[11]) begin
          alu_y = shl_x[DATA_W-1:0];
          alu_c = amt_in_range && shl_x[DATA_W];
        end else begin
          alu_y = shr_x[DATA_W:1];
          alu_c = shr_x[0];
        end
      end
      OP_COMP: alu_y = ~opnd_s;
      default: ;
    endcase
  end

  // Branch condition select against the current PSR.
  always_comb begin
    take = 1'b0;
    case (cc)
      4'd0:    take = 1'b1;
      4'd1:    take = psr_q[1];
      4'd2:    take = psr_q[2];
      4'd3:    take = psr_q[0];
      4'd4:    take = psr_q[3];
      4'd5:    take = psr_q[4];
      4'd6:    take = ~psr_q[0];
      4'd7:    take = ~psr_q[3];
      default: take = 1'b0;
    endcase
  end

  // Next-state, PC, PSR and register write-back decisions.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    psr_d   = psr_q;
    reg_we  = 1'b0;
    reg_wd  = alu_y;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata[31:0];
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (op)
          OP_LOAD:  state_d = S_MEM;
          OP_STORE: begin
            psr_d   = flags(opnd_s, 1'b0);
            state_d = S_MEM;
          end
          OP_BR: begin
            pc_d    = take ? dest[ADDR_W-1:0] : pc_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
          OP_HALT:  state_d = S_HALTED;
          OP_XOR, OP_ADD, OP_ROT, OP_SHIFT, OP_COMP: begin
            reg_we  = 1'b1;
            psr_d   = flags(alu_y, alu_c);
            pc_d    = pc_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
          default: begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        if (mem_ack) begin
          if (op == OP_LOAD) begin
            reg_we = 1'b1;
            reg_wd = mem_rdata;
            psr_d  = flags(mem_rdata, 1'b0);
          end
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_RST;
    endcase
  end

  // Control state, PC, instruction and PSR registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RST;
      pc_q    <= PC_RST;
      ir_q    <= '0;
      psr_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      psr_q   <= psr_d;
    end
  end

  // Register file, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (reg_we) begin
      regs_q[dest[RIW-1:0]] <= reg_wd;
    end
  end

  // Bus outputs decode straight from state so an abandoned request drops
  // in the cycle after reset is sampled.
  always_comb begin
    mem_addr = '0;
    if (state_q == S_FETCH)    mem_addr = pc_q;
    else if (state_q == S_MEM) mem_addr = (op == OP_STORE) ? dest[ADDR_W-1:0] : src[ADDR_W-1:0];
  end

  assign mem_req   = (state_q == S_FETCH) || (state_q == S_MEM);
  assign mem_we    = (state_q == S_MEM) && (op == OP_STORE);
  assign mem_wdata = mem_we ? opnd_s : '0;
  assign halted    = (state_q == S_HALTED);
  assign pc        = pc_q;
  assign psr       = psr_q;

endmodule

// File: tb/tb_multicycle_cpu_core.sv
// Directed bench for multicycle_cpu_core: program image plus a memory
// responder with separate read/write wait-state counts.
module tb_multicycle_cpu_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we, mem_ack, halted;
  logic [11:0] mem_addr, pc;
  logic [31:0] mem_wdata, mem_rdata;
  logic [4:0]  psr;

  logic [31:0] prog [4096];
  logic [31:0] dmem [4096];
  int          dly_rd, dly_wr, wcnt;
  logic        ack_always;
  int          checks, errors;

  multicycle_cpu_core dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .halted(halted), .pc(pc), .psr(psr)
  );

  always #5 clk = ~clk;

  assign mem_rdata = prog[mem_addr];
  assign mem_ack   = ack_always || (mem_req && (wcnt >= (mem_we ? dly_wr : dly_rd)));

  // Wait-state counter and write capture.
  always @(posedge clk) begin
    if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
    if (mem_req && mem_ack && mem_we) dmem[mem_addr] <= mem_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next read request and check its address and spacing.
  task automatic expect_read(input string tag, input logic [11:0] exp_addr, input int exp_gap);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (mem_req && !mem_we) seen = 1;
    end
    chk({tag, " addr"}, 64'(mem_addr), 64'(exp_addr));
    chk({tag, " gap"}, 64'(n), 64'(exp_gap));
  endtask

  initial begin
    int wr_cycles;
    bit stable;
    bit quiet;
    checks = 0;
    errors = 0;
    dly_rd = 0;
    dly_wr = 0;
    wcnt = 0;
    ack_always = 1'b0;
    for (int i = 0; i < 4096; i++) prog[i] = 32'h0;
    prog[0]     = 32'h1001_0001; // LOAD R1 = mem[0x10]
    prog[1]     = 32'h5000_1001; // ADD R1 += R1
    prog[2]     = 32'h2000_1050; // STORE mem[0x50] = R1
    prog[3]     = 32'h9800_0002; // R2 = ~0
    prog[4]     = 32'h5800_1002; // R2 += 1
    prog[5]     = 32'h1001_1003; // LOAD R3 = mem[0x11]
    prog[6]     = 32'h6080_1003; // ROTATE R3 left 1
    prog[7]     = 32'h1001_1003;
    prog[8]     = 32'h7000_4003; // SHIFT R3 right 4
    prog[9]     = 32'h1001_1003;
    prog[10]    = 32'h7002_8003; // SHIFT R3 right 40
    prog[11]    = 32'h2000_3051; // STORE mem[0x51] = R3
    prog[12]    = 32'h4800_0004; // R4 ^= 0
    prog[13]    = 32'h3500_0020; // BRANCH zero -> 0x20
    prog[12'h10] = 32'h0000_0005;
    prog[12'h11] = 32'h8000_0001;
    prog[12'h20] = 32'h5800_1004; // R4 += 1
    prog[12'h21] = 32'h3500_0030; // BRANCH zero (not taken)
    prog[12'h22] = 32'h3900_0030; // BRANCH never
    prog[12'h23] = 32'h2000_4052; // STORE mem[0x52] = R4

    rst = 1'b1;
    tick(); tick(); tick();
    chk("rst req", 64'(mem_req), 64'(0));
    chk("rst we", 64'(mem_we), 64'(0));
    chk("rst addr", 64'(mem_addr), 64'(0));
    chk("rst wdata", 64'(mem_wdata), 64'(0));
    chk("rst halted", 64'(halted), 64'(0));
    chk("rst pc", 64'(pc), 64'(0));
    chk("rst psr", 64'(psr), 64'(0));

    rst = 1'b0;
    tick();
    chk("first req", 64'(mem_req), 64'(1));
    chk("first addr", 64'(mem_addr), 64'(0));

    expect_read("load data", 12'h010, 3);
    expect_read("fetch1", 12'h001, 1);
    expect_read("fetch2", 12'h002, 3);
    chk("add psr", 64'(psr), 64'(5'b00100));
    expect_read("fetch3", 12'h003, 4);
    chk("store R1", 64'(dmem[12'h050]), 64'(32'd10));
    expect_read("fetch4", 12'h004, 3);
    chk("comp psr", 64'(psr), 64'(5'b01000));
    expect_read("fetch5", 12'h005, 3);
    chk("add carry psr", 64'(psr), 64'(5'b10101));
    expect_read("load R3 a", 12'h011, 3);
    expect_read("fetch6", 12'h006, 1);
    chk("load psr", 64'(psr), 64'(5'b01000));
    expect_read("fetch7", 12'h007, 3);
    chk("rotl psr", 64'(psr), 64'(5'b00001));
    expect_read("load R3 b", 12'h011, 3);
    expect_read("fetch8", 12'h008, 1);
    expect_read("fetch9", 12'h009, 3);
    chk("shr4 psr", 64'(psr), 64'(5'b01110));
    expect_read("load R3 c", 12'h011, 3);
    expect_read("fetch10", 12'h00A, 1);
    expect_read("fetch11", 12'h00B, 3);
    chk("shr40 psr", 64'(psr), 64'(5'b01001));
    expect_read("fetch12", 12'h00C, 4);
    chk("store R3", 64'(dmem[12'h051]), 64'(32'hFFFF_FFFF));
    chk("store R3 psr", 64'(psr), 64'(5'b01000));
    expect_read("fetch13", 12'h00D, 3);
    chk("xor psr", 64'(psr), 64'(5'b10100));
    expect_read("br taken", 12'h020, 3);
    expect_read("fetch21", 12'h021, 3);
    chk("add R4 psr", 64'(psr), 64'(5'b00010));
    expect_read("br not taken", 12'h022, 3);
    expect_read("br never", 12'h023, 3);

    // STORE with three write wait states, then stall the next fetch.
    tick();
    dly_wr = 3;
    dly_rd = 50;
    wr_cycles = 0;
    stable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (mem_req && mem_we) begin
        wr_cycles++;
        if (mem_addr !== 12'h052 || mem_wdata !== 32'd1) stable = 1'b0;
      end
    end
    chk("store req cycles", 64'(wr_cycles), 64'(4));
    chk("store stable", 64'(stable), 64'(1));
    chk("store R4", 64'(dmem[12'h052]), 64'(32'd1));
    chk("stall req", 64'(mem_req), 64'(1));
    chk("stall addr", 64'(mem_addr), 64'(12'h024));
    rst = 1'b1;
    tick();
    chk("abandon req", 64'(mem_req), 64'(0));
    chk("abandon pc", 64'(pc), 64'(0));
    chk("abandon addr", 64'(mem_addr), 64'(0));

    // HALT at address 7 after a run of NOPs.
    tick(); tick();
    dly_rd = 0;
    dly_wr = 0;
    for (int i = 0; i < 64; i++) prog[i] = 32'h0;
    prog[7] = 32'h8000_0000;
    chk("rst2 psr", 64'(psr), 64'(0));
    rst = 1'b0;
    tick();
    chk("fetch0 again", 64'(mem_addr), 64'(0));
    for (int a = 1; a < 8; a++) expect_read("nop run", 12'(a), 3);
    tick();
    chk("halt decode", 64'(halted), 64'(0));
    tick();
    chk("halt exec", 64'(halted), 64'(0));
    tick();
    chk("halted", 64'(halted), 64'(1));
    chk("halted pc", 64'(pc), 64'(7));
    ack_always = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_req !== 1'b0 || halted !== 1'b1) quiet = 1'b0;
    end
    chk("halted quiet", 64'(quiet), 64'(1));
    chk("halted pc hold", 64'(pc), 64'(7));
    rst = 1'b1;
    ack_always = 1'b0;
    tick(); tick();
    chk("unhalt", 64'(halted), 64'(0));
    chk("unhalt pc", 64'(pc), 64'(0));
    rst = 1'b0;
    tick();
    chk("restart req", 64'(mem_req), 64'(1));
    chk("restart addr", 64'(mem_addr), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
